// File: rtl/normalizer_if.sv
// Handshake bundle for the normalizer: operand in, normalized result out.
// Both sides use valid/ready. A beat transfers on a rising edge where valid and ready are both 1.
// The payload is held steady while valid is 1 and ready is 0.
interface normalizer_if #(
    parameter int MANTISSA = 11,
    parameter int EXPONENT = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [MANTISSA:0]   in_sum;
    logic [EXPONENT-1:0] in_exp;
    logic                out_valid;
    logic                out_ready;
    logic                out_sign;
    logic [MANTISSA-1:0] out_mantissa;
    logic [EXPONENT-1:0] out_exp;
    logic                out_zero;
    logic                out_overflow;
    logic                out_underflow;

    modport master (
        output in_valid, in_sum, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_mantissa, out_exp,
               out_zero, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sum, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_mantissa, out_exp,
               out_zero, out_overflow, out_underflow
    );
endinterface

// File: rtl/normalizer.sv
// Normalizes a two's-complement aligned mantissa sum to sign/magnitude with the hidden bit at the MSB.
// Uses one right shift or a sequence of single-bit left shifts, and adjusts the exponent.
module normalizer #(
    parameter int MANTISSA = 11,
    parameter int EXPONENT = 5
) (
    input  logic        clk,
    input  logic        rstn,
    normalizer_if.slave bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, DONE} state_e;

    localparam logic [EXPONENT-1:0] EXP_MAX = '1;
    localparam logic [EXPONENT-1:0] EXP_ONE = {{(EXPONENT-1){1'b0}}, 1'b1};
    localparam logic [MANTISSA:0]   MAG_ONE = {{MANTISSA{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [MANTISSA:0]   mag_q, mag_d;
    logic [EXPONENT-1:0] exp_q, exp_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [MANTISSA:0]   shl_mag;
    logic [EXPONENT-1:0] dec_exp;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        shl_mag = {mag_q[MANTISSA-1:0], 1'b0};
        dec_exp = exp_q - EXP_ONE;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // The most negative sum becomes 2^MANTISSA, which is why mag is one bit wider
                    sign_d  = bus.in_sum[MANTISSA];
                    mag_d   = bus.in_sum[MANTISSA] ? (~bus.in_sum + MAG_ONE) : bus.in_sum;
                    exp_d   = bus.in_exp;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                state_d = DONE;
                if (mag_q == '0) begin
                    zero_d = 1'b1;
                    sign_d = 1'b0;
                    exp_d  = '0;
                end else if (mag_q[MANTISSA]) begin
                    if (exp_q != EXP_MAX) begin
                        mag_d = mag_q >> 1;
                        exp_d = exp_q + EXP_ONE;
                    end else begin
                        ovf_d = 1'b1;
                        mag_d = {1'b0, {MANTISSA{1'b1}}};
                    end
                end else if (!mag_q[MANTISSA-1]) begin
                    if (exp_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mag_d = shl_mag;
                exp_d = dec_exp;
                // A new hidden bit wins over reaching exponent zero on the same step
                if (shl_mag[MANTISSA-1]) begin
                    state_d = DONE;
                end else if (dec_exp == '0) begin
                    unf_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE) && rstn;
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_sign      = sign_q;
    assign bus.out_mantissa  = mag_q[MANTISSA-1:0];
    assign bus.out_exp       = exp_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for the normalizer. Result words are {sign, mantissa, exp, zero, overflow, underflow}.
// Latency is the number of edges from the input transfer edge to the first edge that samples out_valid=1.
module tb_normalizer;
    localparam int M = 11;
    localparam int E = 5;
    localparam int W = 1 + M + E + 3;

    logic       clk;
    logic       rstn;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    normalizer_if #(.MANTISSA(M), .EXPONENT(E)) bus ();

    normalizer #(.MANTISSA(M), .EXPONENT(E)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] observed();
        return {bus.out_sign, bus.out_mantissa, bus.out_exp,
                bus.out_zero, bus.out_overflow, bus.out_underflow};
    endfunction

    function automatic logic [W-1:0] pack(input logic s, input logic [M-1:0] mant,
                                          input logic [E-1:0] ev, input logic [2:0] flags);
        return {s, mant, ev, flags};
    endfunction

    // Reference model: priority-encode the leading one instead of stepping shift by shift
    task automatic model(input logic [M:0] sum, input logic [E-1:0] ex,
                         output logic [W-1:0] word, output int lat);
        logic s;
        logic [M:0] mag;
        logic [M-1:0] mant;
        logic [E-1:0] ev;
        logic z, o, u;
        int p, sh, k;
        s = sum[M];
        mag = s ? (~sum + 12'd1) : sum;
        mant = '0; ev = ex; z = 1'b0; o = 1'b0; u = 1'b0; lat = 2;
        if (mag == '0) begin
            z = 1'b1; s = 1'b0; ev = '0;
        end else if (mag[M]) begin
            if (ex == 5'd31) begin
                o = 1'b1; mant = '1;
            end else begin
                mant = mag[M:1]; ev = ex + 5'd1;
            end
        end else begin
            p = 0;
            for (int i = 0; i < M; i++) if (mag[i]) p = i;
            sh = M - 1 - p;
            u = (sh > int'(ex));
            k = u ? int'(ex) : sh;
            mant = mag[M-1:0] << k;
            ev = ex - 5'(k);
            lat = 2 + k;
        end
        word = {s, mant, ev, z, o, u};
    endtask

    task automatic send(input logic [M:0] sum, input logic [E-1:0] ex);
        int n;
        n = 0;
        bus.in_sum = sum;
        bus.in_exp = ex;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        int n, want_lat;
        logic [W-1:0] want, obs;
        n = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 64) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_valid: out_valid=%b queued=%0d, required out_valid=1 with a queued result",
                     name, bus.out_valid, exp_q.size());
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(lat_q.pop_front());
            end
        end else begin
            want = exp_q.pop_front();
            want_lat = lat_q.pop_front();
            obs = observed();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s_result: got %h, required %h", name, obs, want);
            end
            checks++;
            if (n + 1 != want_lat) begin
                failures++;
                $display("FAIL %s_latency: got %0d, required %0d", name, n + 1, want_lat);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0/1",
                         name, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctrl: out_valid=%b in_ready=%b state=%0d, required 0/0/0",
                     bus.out_valid, bus.in_ready, dbg_state);
        end
        checks++;
        if (observed() !== '0) begin
            failures++;
            $display("FAIL reset_fields: got %h, required 0", observed());
        end
        bus.in_valid = 1'b0;
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_directed(input string name, input int cnt,
                                 input logic [M:0] sums[4], input logic [E-1:0] exps[4],
                                 input logic [W-1:0] words[4], input int lats[4]);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(words[i]);
            lat_q.push_back(lats[i]);
            send(sums[i], exps[i]);
            collect(name);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] snap, want;
        int n;
        exp_q.push_back(pack(1'b0, 11'h400, 5'd10, 3'b000));
        lat_q.push_back(2);
        send(12'h400, 5'd10);
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 64) begin
            @(posedge clk); #1; n++;
        end
        snap = observed();
        want = exp_q.pop_front();
        void'(lat_q.pop_front());
        checks++;
        if (bus.out_valid !== 1'b1 || snap !== want) begin
            failures++;
            $display("FAIL stall_result: out_valid=%b got %h, required 1/%h", bus.out_valid, snap, want);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0] ? 1'b0 : 1'b1;
            bus.in_sum = 12'($urandom_range(0, 4095));
            bus.in_exp = 5'($urandom_range(0, 31));
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_in_ready: in_ready=%b, required 0", bus.in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || observed() !== snap) begin
                failures++;
                $display("FAIL stall_hold: out_valid=%b got %h, required 1/%h", bus.out_valid, observed(), snap);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || dbg_state !== 2'd0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: out_valid=%b state=%0d in_ready=%b, required 0/0/1",
                     bus.out_valid, dbg_state, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        send(12'h001, 5'd20);
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL midreset_in_shift: state=%0d, required 2", dbg_state);
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || dbg_state !== 2'd0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_edge: out_valid=%b state=%0d in_ready=%b, required 0/0/0",
                     bus.out_valid, dbg_state, bus.in_ready);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: in_ready=%b, required 1", bus.in_ready);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midreset_no_output: out_valid high %0d cycles, required 0", seen);
        end
        exp_q.push_back(pack(1'b0, 11'h400, 5'd10, 3'b000));
        lat_q.push_back(2);
        send(12'h400, 5'd10);
        collect("midreset_next");
    endtask

    task automatic test_back_to_back();
        logic [M:0] sums[6];
        logic [E-1:0] exps[6];
        logic [W-1:0] want, word;
        int idx, outs, cyc, last, lat;
        logic accepted;
        for (int i = 0; i < 6; i++) begin
            sums[i] = 12'h400 | 12'($urandom_range(0, 1023));
            if (i % 2 == 1) sums[i] = ~sums[i] + 12'd1;
            exps[i] = 5'($urandom_range(0, 31));
        end
        idx = 0; outs = 0; cyc = 0; last = -1;
        bus.out_ready = 1'b1;
        bus.in_sum = sums[0];
        bus.in_exp = exps[0];
        bus.in_valid = 1'b1;
        while (outs < 6 && cyc < 100) begin
            accepted = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected: out_valid=1 with empty queue, required no output");
                end else begin
                    want = exp_q.pop_front();
                    void'(lat_q.pop_front());
                    if (observed() !== want) begin
                        failures++;
                        $display("FAIL b2b_result: got %h, required %h", observed(), want);
                    end
                end
                outs++;
            end
            if (accepted) begin
                model(bus.in_sum, bus.in_exp, word, lat);
                exp_q.push_back(word);
                lat_q.push_back(lat);
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        failures++;
                        $display("FAIL b2b_interval: got %0d cycles, required 3", cyc - last);
                    end
                end
                last = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                idx++;
                if (idx < 6) begin
                    bus.in_sum = sums[idx];
                    bus.in_exp = exps[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (outs != 6) begin
            failures++;
            $display("FAIL b2b_count: got %0d results, required 6", outs);
        end
    endtask

    task automatic test_random();
        logic [M:0] sum;
        logic [E-1:0] ex;
        logic [W-1:0] word;
        int lat;
        for (int i = 0; i < 24; i++) begin
            sum = 12'($urandom_range(0, 4095));
            if (i % 4 == 0) sum = sum >> $urandom_range(4, 11);
            ex = 5'($urandom_range(0, 31));
            model(sum, ex, word, lat);
            exp_q.push_back(word);
            lat_q.push_back(lat);
            send(sum, ex);
            collect("random");
        end
    endtask

    initial begin
        logic [M:0] s_tab[4];
        logic [E-1:0] e_tab[4];
        logic [W-1:0] w_tab[4];
        int l_tab[4];
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sum = '0;
        bus.in_exp = '0;
        bus.out_ready = 1'b1;

        test_reset();

        s_tab = '{12'h400, 12'h800, 12'h800, 12'h7FF};
        e_tab = '{5'd10, 5'd3, 5'd31, 5'd0};
        w_tab = '{pack(1'b0, 11'h400, 5'd10, 3'b000), pack(1'b1, 11'h400, 5'd4, 3'b000),
                  pack(1'b1, 11'h7FF, 5'd31, 3'b010), pack(1'b0, 11'h7FF, 5'd0, 3'b000)};
        l_tab = '{2, 2, 2, 2};
        test_directed("align", 4, s_tab, e_tab, w_tab, l_tab);

        s_tab = '{12'h001, 12'hFFF, 12'h200, 12'h000};
        e_tab = '{5'd20, 5'd20, 5'd1, 5'd0};
        w_tab = '{pack(1'b0, 11'h400, 5'd10, 3'b000), pack(1'b1, 11'h400, 5'd10, 3'b000),
                  pack(1'b0, 11'h400, 5'd0, 3'b000), pack(1'b0, 11'h000, 5'd0, 3'b100)};
        l_tab = '{12, 12, 3, 2};
        test_directed("left_shift", 4, s_tab, e_tab, w_tab, l_tab);

        s_tab = '{12'h004, 12'h000, 12'h100, 12'hC00};
        e_tab = '{5'd3, 5'd17, 5'd0, 5'd7};
        w_tab = '{pack(1'b0, 11'h020, 5'd0, 3'b001), pack(1'b0, 11'h000, 5'd0, 3'b100),
                  pack(1'b0, 11'h100, 5'd0, 3'b001), pack(1'b1, 11'h400, 5'd7, 3'b000)};
        l_tab = '{5, 2, 2, 2};
        test_directed("underflow_zero", 4, s_tab, e_tab, w_tab, l_tab);

        test_stall();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained: %0d results left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/normalizer.md
NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 SHALL have parameter MANTISSA, default 11: mantissa width in bits, including the hidden bit.
REQ-002 SHALL have parameter EXPONENT, default 5: exponent width in bits, unsigned.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: an input operand is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operand; a transfer occurs on an edge where in_valid=1 and in_ready=1.
REQ-007 SHALL have port in_sum, input, MANTISSA+1 bits: two's-complement aligned mantissa sum.
REQ-008 SHALL have port in_exp, input, EXPONENT bits: common exponent of the sum.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts; a transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-011 SHALL have port out_sign, output, 1 bit: sign of the result (1 = negative).
REQ-012 SHALL have port out_mantissa, output, MANTISSA bits: normalized magnitude, hidden bit at the MSB.
REQ-013 SHALL have port out_exp, output, EXPONENT bits: adjusted exponent.
REQ-014 SHALL have port out_zero, output, 1 bit: the result is exactly zero.
REQ-015 SHALL have port out_overflow, output, 1 bit: the exponent saturated.
REQ-016 SHALL have port out_underflow, output, 1 bit: the exponent reached 0 before normalization completed.

Function
REQ-017 SHALL implement FSM states IDLE, ALIGN, SHIFT and DONE; in_ready SHALL be 1 only in IDLE with rstn=1.
REQ-018 In IDLE on a transfer, the block SHALL register:
- sign = in_sum[MANTISSA];
- mag = |in_sum| as an unsigned MANTISSA+1-bit value (the most negative input gives 2^MANTISSA);
- exp = in_exp;
then go to ALIGN.
REQ-019 In ALIGN, the first matching rule in the following order SHALL apply:
- mag==0: out_zero=1, mantissa=0, exp=0, sign=0, go to DONE.
- mag[MANTISSA]=1 and exp<all-ones: mag>>1 with the LSB truncated, exp+1, go to DONE.
- mag[MANTISSA]=1 and exp=all-ones: out_overflow=1, mantissa=all-ones, exp=all-ones, go to DONE.
- mag[MANTISSA-1]=1: go to DONE unchanged.
- exp==0: out_underflow=1, go to DONE unchanged.
- otherwise: go to SHIFT.
REQ-020 In SHIFT, each cycle SHALL shift mag left by 1 and decrement exp by 1.
- After the shift, if the new MSB (mag[MANTISSA-1]) is 1, go to DONE.
- Else, if the new exp is 0, set out_underflow=1 and go to DONE.
- Else, remain in SHIFT.
REQ-021 Latency SHALL be:
- 2 cycles from the input transfer edge to out_valid=1 when no left shift is needed;
- 2+k cycles when k left shifts occur.
REQ-022 In DONE, out_valid SHALL be 1, and all out_* outputs SHALL hold stable until the output transfer; the transfer edge returns the FSM to IDLE.
REQ-023 The next input SHALL NOT be accepted on the same edge as an output transfer; the minimum issue interval is 3 cycles.
REQ-024 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-025 Flags SHALL be mutually exclusive and SHALL be cleared on each new input transfer.
REQ-026 The block SHALL NOT round: a right-shifted LSB is discarded.

Reset
REQ-027 While rstn=0 at a rising edge, the block SHALL:
- set the state to IDLE;
- set out_valid, out_sign, out_mantissa, out_exp, out_zero, out_overflow and out_underflow to 0;
- drive in_ready=0.
REQ-028 Reset asserted in any state SHALL discard the operation in progress; out_valid SHALL be 0 after that edge, and in_ready SHALL be 1 in the first cycle with rstn=1.

Verification
REQ-029 in_sum=12'h400, in_exp=10 -> sign 0, mantissa 11'h400, exp 10, out_valid 2 cycles after acceptance.
REQ-030 in_sum=12'h800, in_exp=3 -> sign 1, mantissa 11'h400, exp 4; with in_exp=31 -> out_overflow=1, mantissa 11'h7FF, exp 31.
REQ-031 in_sum=12'h001, in_exp=20 -> mantissa 11'h400, exp 10, latency 12 cycles; in_sum=12'hFFF (-1), in_exp=20 -> same values with sign 1.
REQ-032 in_sum=12'h004, in_exp=3 -> out_underflow=1, mantissa 11'h020, exp 0, latency 5 cycles; in_sum=0 -> out_zero=1, all fields 0, latency 2 cycles.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no input accepted; the release edge returns the FSM to IDLE.
REQ-034 Assert rstn=0 during the 4th SHIFT cycle of in_sum=12'h001 -> out_valid never rises for that operand; the next operand (12'h400, exp 10) completes per REQ-029.
